main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
- Backing-memory responder on the far end of the cache miss interface.
- Accepts one word read/write request at a time from the cache miss path.
- Models configurable access latency, commits byte-masked writes, and returns the addressed word with a one-cycle `main_mem_valid_o` pulse.
- Feeds `main_mem_valid_i` / `main_mem_data_i` of the data cache hierarchy and replaces the zero-latency memory in system simulation.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 (byte-enable encodings assume 4 lanes).
- MEM_ADDR_BITS, 17, log2 of storage depth in words (128K words = 512 KB).
- READ_LATENCY, 4, cycles from request acceptance to response for reads; legal range 1..15.
- WRITE_LATENCY, 2, cycles from acceptance to response for writes; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept a request this cycle
- req_wr_en_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wr_data_i  in  DATA_WIDTH  write data, lane-aligned at bit 0
- req_byte_en_i  in  4  0001 byte, 0011 half, 1111 word
- main_mem_valid_o  out  1  one-cycle response strobe
- main_mem_data_o  out  DATA_WIDTH  response word
- busy_o  out  1  request outstanding
- err_o  out  1  one-cycle pulse with response when byte enable was illegal

Behaviour:
- Reset values, applied at the first clk edge with rst=1: state IDLE, req_ready_o=1, main_mem_valid_o=0, main_mem_data_o=0, busy_o=0, err_o=0, latency counter=0.
- Reset does not clear storage contents.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i && req_ready_o (cycle T):
  - Capture wr_en, addr, wr_data and byte_en.
  - Load counter with (wr_en ? WRITE_LATENCY : READ_LATENCY) - 1.
  - Go to RESP if the loaded value is 0, else go to WAIT.
- WAIT: req_ready_o=0, busy_o=1. Decrement the counter each cycle; go to RESP when the counter reaches 1→0.
- RESP: lasts one cycle, at T+L with L = the applicable latency.
  - main_mem_valid_o=1, busy_o=1, req_ready_o=0.
  - main_mem_data_o = stored word at the pre-write value, full 32 bits, regardless of byte_en.
  - For a write with a legal byte enable, the masked merge is committed at the clk edge ending RESP.
  - Next state is IDLE, so req_ready_o=1 at T+L+1.
  - Maximum throughput is one request per L+1 cycles.
- main_mem_data_o holds its last value outside RESP; consumers qualify it with main_mem_valid_o only.
- Word index = req_addr_i[MEM_ADDR_BITS+1:2]. Upper bits are ignored, so addresses wrap modulo depth. req_addr_i[1:0] is ignored for lane selection.
- Byte lanes are always the low lanes of the word; there is no shifting by address offset:
  - 0001 writes [7:0].
  - 0011 writes [15:0].
  - 1111 writes [31:0].
  - Unwritten lanes keep their stored value.
- Illegal byte_en (any other value, including 0000):
  - No storage update.
  - Response is still issued with the stored word.
  - err_o=1 in the RESP cycle.
- req_valid_i while req_ready_o=0 is ignored. The requester must hold the request until it sees ready. Only the request fields present at the acceptance edge are used.
- Simultaneous rst and acceptance: reset wins, and the request is dropped.
- rst during WAIT or RESP:
  - Return to IDLE next cycle.
  - main_mem_valid_o=0.
  - Any pending write is discarded, including one in RESP, because reset blocks the commit.
- Storage is initialised to zero at time 0 (simulation initial block).

Decomposition:
- Package main_mem_pkg holds:
  - State enum mm_state_e {MM_IDLE, MM_WAIT, MM_RESP}.
  - Byte-enable constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
  - Function be_legal(be).
  - Function be_merge(old, new, be), which returns the merged word; the cache fill path reuses it.
- One sub-module, mem_word_array:
  - Single-port, 2^MEM_ADDR_BITS x 32.
  - Combinational read of the indexed word; synchronous full-word write with we.
  - The FSM drives the merged word into it.

Test Plan:
- Read latency: after reset, preload word index 0x10 = 0xDEADBEEF; read addr 0x40 accepted at cycle T → main_mem_valid_o=1 only at T+4, data 0xDEADBEEF, req_ready_o=0 over T+1..T+4, 1 at T+5.
- Byte write: word 0x40 = 0x11223344; write addr 0x40, be=0001, data 0x000000AA → response data 0x11223344 at T+2; subsequent read returns 0x112233AA. Repeat with be=0011, data 0xBBCC → read 0x1122BBCC.
- Illegal byte enable: write be=0101, data 0xFFFFFFFF to word 0x11223344 → err_o=1 with valid at T+2, read-back 0x11223344; err_o=0 on every other cycle.
- Back-to-back and wrap: req_valid_i held high with reads to 0x0 then 0x0008_0000 (wraps to index 0 at 17 bits) → second acceptance at T+5, both responses return the same word, exactly two valid pulses.
- Reset mid-operation: write 0xCAFEF00D be=1111 to addr 0x80, assert rst for one cycle at T+1 → no valid pulse, req_ready_o=1 after reset, read of 0x80 returns its prior value 0x00000000.
- Minimum latency: rebuild with READ_LATENCY=1 → valid at T+1, ready at T+2; a request held during T+1 is accepted at T+2.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared types and byte-lane helpers for the backing-memory responder.
// be_merge is also used by the cache fill path.
package main_mem_pkg;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_WAIT,
    MM_RESP
  } mm_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    return (be == BE_BYTE) || (be == BE_HALF) || (be == BE_WORD);
  endfunction

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/main_mem_responder_array.sv
// Single-port word storage: combinational read, synchronous full-word write.
// Contents are deliberately not reset.
module mem_word_array #(
  parameter int ADDR_BITS  = 17,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_BITS-1:0]  idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/main_mem_responder.sv
// Backing-memory responder for the cache miss path: one request at a time,
// fixed read/write latency, byte-masked write committed at the end of RESP.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 17,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wr_data_i,
  input  logic [3:0]            req_byte_en_i,
  output logic                  main_mem_valid_o,
  output logic [DATA_WIDTH-1:0] main_mem_data_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam logic [3:0] RLAT_M1 = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WLAT_M1 = 4'(WRITE_LATENCY - 1);

  mm_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [MEM_ADDR_BITS-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0] be_q, be_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Byte offset and bits above the storage depth are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{req_addr_i[ADDR_WIDTH-1:MEM_ADDR_BITS+2],
                         req_addr_i[1:0]};

  mem_word_array #(
    .ADDR_BITS  (MEM_ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .idx_i   (idx_q),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign mem_wdata = be_merge(mem_rdata, wdata_q, be_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    unique case (state_q)
      MM_IDLE: begin
        if (req_valid_i) begin
          wr_d    = req_wr_en_i;
          idx_d   = req_addr_i[MEM_ADDR_BITS+1:2];
          wdata_d = req_wr_data_i;
          be_d    = req_byte_en_i;
          cnt_d   = req_wr_en_i ? WLAT_M1 : RLAT_M1;
          state_d = (cnt_d == 4'd0) ? MM_RESP : MM_WAIT;
        end
      end
      MM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = MM_RESP;
        end
      end
      MM_RESP: begin
        state_d = MM_IDLE;
        data_d  = mem_rdata;
        // A reset landing on RESP must still block the commit.
        mem_we  = wr_q && be_legal(be_q) && !rst;
      end
      default: state_d = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MM_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= 4'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      data_q  <= data_d;
    end
  end

  assign req_ready_o      = (state_q == MM_IDLE);
  assign busy_o           = (state_q != MM_IDLE);
  assign main_mem_valid_o = (state_q == MM_RESP);
  assign err_o            = main_mem_valid_o && !be_legal(be_q);
  assign main_mem_data_o  = main_mem_valid_o ? mem_rdata : data_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed self-checking bench for main_mem_responder.
// A second instance covers the one-cycle read latency corner.
module tb_main_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_wr;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_be;
  logic        req_ready, mm_valid, busy, err;
  logic [31:0] mm_data;

  logic        rst1, req_valid1, req_wr1;
  logic [31:0] req_addr1, req_data1;
  logic [3:0]  req_be1;
  logic        req_ready1, mm_valid1, busy1, err1;
  logic [31:0] mm_data1;

  main_mem_responder dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_wr_en_i      (req_wr),
    .req_addr_i       (req_addr),
    .req_wr_data_i    (req_data),
    .req_byte_en_i    (req_be),
    .main_mem_valid_o (mm_valid),
    .main_mem_data_o  (mm_data),
    .busy_o           (busy),
    .err_o            (err)
  );

  main_mem_responder #(.READ_LATENCY(1)) dut1 (
    .clk              (clk),
    .rst              (rst1),
    .req_valid_i      (req_valid1),
    .req_ready_o      (req_ready1),
    .req_wr_en_i      (req_wr1),
    .req_addr_i       (req_addr1),
    .req_wr_data_i    (req_data1),
    .req_byte_en_i    (req_be1),
    .main_mem_valid_o (mm_valid1),
    .main_mem_data_o  (mm_data1),
    .busy_o           (busy1),
    .err_o            (err1)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int n_stray_err = 0;

  always @(negedge clk) begin
    if (mm_valid) n_pulse++;
    if (err && !mm_valid) n_stray_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        rerr,
    output int          lat,
    output logic        rdy_ok
  );
    int g;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_data  = data;
    req_be    = be;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) chk("ready_timeout", 32'(g), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = 32'hx5x5x5x5;
    lat = 1;
    rdy_ok = 1'b1;
    while (!mm_valid && lat < 20) begin
      if (req_ready) rdy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (req_ready) rdy_ok = 1'b0;
    rdata = mm_data;
    rerr  = err;
    @(negedge clk);
    if (!req_ready) rdy_ok = 1'b0;
  endtask

  logic [31:0] rd;
  logic        re, rok;
  int          lat, p0, v1, v2;
  logic [31:0] d1, d2;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_data = '0; req_be = 4'd0;
    rst1 = 1'b1; req_valid1 = 1'b0; req_wr1 = 1'b0;
    req_addr1 = '0; req_data1 = '0; req_be1 = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(mm_valid), 32'd0);
    chk("rst_data", mm_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0; rst1 = 1'b0;

    // read latency
    do_req(1'b1, 32'h40, 32'hDEADBEEF, 4'b1111, rd, re, lat, rok);
    chk("wr_lat", 32'(lat), 32'd2);
    do_req(1'b0, 32'h40, 32'h0, 4'b1111, rd, re, lat, rok);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_ready_seq", 32'(rok), 32'd1);

    // byte and half writes to the low lanes
    do_req(1'b1, 32'h40, 32'h11223344, 4'b1111, rd, re, lat, rok);
    chk("wword_prewrite", rd, 32'hDEADBEEF);
    do_req(1'b1, 32'h40, 32'h000000AA, 4'b0001, rd, re, lat, rok);
    chk("wbyte_lat", 32'(lat), 32'd2);
    chk("wbyte_prewrite", rd, 32'h11223344);
    chk("wbyte_ready_seq", 32'(rok), 32'd1);
    do_req(1'b0, 32'h40, 32'h0, 4'b1111, rd, re, lat, rok);
    chk("rbyte_data", rd, 32'h112233AA);
    do_req(1'b1, 32'h42, 32'h0000BBCC, 4'b0011, rd, re, lat, rok);
    chk("whalf_prewrite", rd, 32'h112233AA);
    do_req(1'b0, 32'h40, 32'h0, 4'b1111, rd, re, lat, rok);
    chk("rhalf_data", rd, 32'h1122BBCC);

    // illegal byte enable
    do_req(1'b1, 32'h40, 32'h11223344, 4'b1111, rd, re, lat, rok);
    chk("wword_err", 32'(re), 32'd0);
    do_req(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0101, rd, re, lat, rok);
    chk("ill_err", 32'(re), 32'd1);
    chk("ill_lat", 32'(lat), 32'd2);
    chk("ill_data", rd, 32'h11223344);
    do_req(1'b0, 32'h40, 32'h0, 4'b1111, rd, re, lat, rok);
    chk("ill_readback", rd, 32'h11223344);
    chk("ill_readback_err", 32'(re), 32'd0);
    do_req(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, rd, re, lat, rok);
    chk("zero_be_err", 32'(re), 32'd1);
    do_req(1'b0, 32'h40, 32'h0, 4'b1111, rd, re, lat, rok);
    chk("zero_be_readback", rd, 32'h11223344);

    // back-to-back with address wrap
    do_req(1'b1, 32'h0, 32'h55667788, 4'b1111, rd, re, lat, rok);
    @(negedge clk);
    p0 = n_pulse;
    v1 = 0; v2 = 0; d1 = '0; d2 = '0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0; req_be = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req_addr = 32'h0008_0000;
      if (k == 5) chk("b2b_ready_t5", 32'(req_ready), 32'd1);
      if (k == 6) req_valid = 1'b0;
      if (mm_valid && v1 == 0) begin
        v1 = k; d1 = mm_data;
      end else if (mm_valid) begin
        v2 = k; d2 = mm_data;
      end
    end
    chk("b2b_pulses", 32'(n_pulse - p0), 32'd2);
    chk("b2b_first_at", 32'(v1), 32'd4);
    chk("b2b_second_at", 32'(v2), 32'd9);
    chk("b2b_first_data", d1, 32'h55667788);
    chk("b2b_wrap_data", d2, 32'h55667788);

    // reset during WAIT drops the write
    do_req(1'b1, 32'h80, 32'h0, 4'b1111, rd, re, lat, rok);
    @(negedge clk);
    p0 = n_pulse;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h80;
    req_data = 32'hCAFEF00D; req_be = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("rstw_pulses", 32'(n_pulse - p0), 32'd0);
    do_req(1'b0, 32'h80, 32'h0, 4'b1111, rd, re, lat, rok);
    chk("rstw_readback", rd, 32'h0);

    // reset during RESP blocks the commit
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h80;
    req_data = 32'h12345678; req_be = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstr_in_resp", 32'(mm_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstr_valid_after", 32'(mm_valid), 32'd0);
    chk("rstr_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h80, 32'h0, 4'b1111, rd, re, lat, rok);
    chk("rstr_readback", rd, 32'h0);

    chk("err_stray", 32'(n_stray_err), 32'd0);

    // one-cycle read latency instance
    @(negedge clk);
    req_valid1 = 1'b1; req_wr1 = 1'b1; req_addr1 = 32'h4;
    req_data1 = 32'hA5A5A5A5; req_be1 = 4'b1111;
    @(negedge clk);
    req_valid1 = 1'b0;
    lat = 1;
    while (!mm_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("l1_wr_lat", 32'(lat), 32'd2);
    @(negedge clk);
    chk("l1_ready_idle", 32'(req_ready1), 32'd1);
    req_valid1 = 1'b1; req_wr1 = 1'b0; req_addr1 = 32'h4;
    @(negedge clk);
    chk("l1_valid_t1", 32'(mm_valid1), 32'd1);
    chk("l1_ready_t1", 32'(req_ready1), 32'd0);
    chk("l1_data_t1", mm_data1, 32'hA5A5A5A5);
    @(negedge clk);
    chk("l1_valid_t2", 32'(mm_valid1), 32'd0);
    chk("l1_ready_t2", 32'(req_ready1), 32'd1);
    chk("l1_data_hold", mm_data1, 32'hA5A5A5A5);
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("l1_valid_t3", 32'(mm_valid1), 32'd1);
    @(negedge clk);
    chk("l1_valid_t4", 32'(mm_valid1), 32'd0);
    chk("l1_err", 32'(err1), 32'd0);
    chk("l1_busy", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
